scs8hd_o4na_sync: RTL and testbench



---
 rtl/scs8hd_o4na_sync.sv | 126 ++++++++++++
 tb/tb_scs8hd_o4na_sync.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/scs8hd_o4na_sync.sv
// Registered multi-channel OR-AND: f[c] = (|A[c]) & B[c], valid-tagged pipeline,
// then a per-channel conditioner (pass / sticky / pulse-stretch).
module scs8hd_o4na_sync #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned NOR     = 4,
    parameter int unsigned STAGES  = 2,
    parameter int unsigned STRETCH = 3
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NCH*NOR-1:0] A,
    input  logic [NCH-1:0]     B,
    input  logic               IN_VALID,
    input  logic [1:0]         MODE,
    input  logic [NCH-1:0]     CLR,
    output logic [NCH-1:0]     X,
    output logic               OUT_VALID,
    output logic               ANY
);

    localparam int unsigned     CW       = (STRETCH > 0) ? $clog2(STRETCH + 1) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(STRETCH);

    typedef enum logic [1:0] {
        MODE_PASS    = 2'b00,
        MODE_STICKY  = 2'b01,
        MODE_STRETCH = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_t;

    mode_t          mode_q;
    logic           mode_chg;
    logic [NCH-1:0] f;
    logic [NCH-1:0] r;
    logic           rv;
    logic [CW-1:0]  cnt [NCH];

    always_comb begin
        f = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            f[c] = (|A[c*NOR +: NOR]) & B[c];
        end
    end

    assign mode_chg = (mode_t'(MODE) != mode_q);

    generate
        if (STAGES == 1) begin : g_direct
            assign r  = f;
            assign rv = IN_VALID;
        end else begin : g_pipe
            localparam int unsigned DS = STAGES - 1;
            logic [NCH-1:0] d [DS];
            logic [DS-1:0]  v;

            // Valid advances every cycle so bubbles propagate; data only moves with a valid.
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    v <= '0;
                    for (int unsigned i = 0; i < DS; i++) begin
                        d[i] <= '0;
                    end
                end else begin
                    v[0] <= IN_VALID;
                    if (IN_VALID) begin
                        d[0] <= f;
                    end
                    for (int unsigned i = 1; i < DS; i++) begin
                        v[i] <= v[i-1];
                        if (v[i-1]) begin
                            d[i] <= d[i-1];
                        end
                    end
                end
            end

            assign r  = d[DS-1];
            assign rv = v[DS-1];
        end
    endgenerate

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            X         <= '0;
            OUT_VALID <= 1'b0;
            mode_q    <= MODE_PASS;
            for (int unsigned c = 0; c < NCH; c++) begin
                cnt[c] <= '0;
            end
        end else begin
            OUT_VALID <= rv;
            mode_q    <= mode_t'(MODE);
            for (int unsigned c = 0; c < NCH; c++) begin
                case (mode_q)
                    MODE_STICKY: begin
                        // Set term is OR'd after the clear so a coincident event survives.
                        X[c] <= (X[c] & ~CLR[c]) | (rv & r[c]);
                    end
                    MODE_STRETCH: begin
                        if (rv && r[c]) begin
                            X[c]   <= 1'b1;
                            cnt[c] <= CNT_LOAD;
                        end else if (cnt[c] != '0) begin
                            X[c]   <= 1'b1;
                            cnt[c] <= cnt[c] - CW'(1);
                        end else if (rv) begin
                            X[c] <= 1'b0;
                        end
                    end
                    default: begin
                        if (rv) begin
                            X[c] <= r[c];
                        end
                    end
                endcase
                // Overrides any stretch update in the cycle a mode change is seen.
                if (mode_chg) begin
                    cnt[c] <= '0;
                end
            end
        end
    end

    assign ANY = |X;

endmodule

// File: tb/tb_scs8hd_o4na_sync.sv
// Bench for scs8hd_o4na_sync (NCH=4, NOR=4, STAGES=2, STRETCH=3): pass-mode vector table
// scored through a queue, plus hand sequences for sticky, stretch, mode change and reset.
module tb_scs8hd_o4na_sync;

    logic        CLK;
    logic        RESET;
    logic [15:0] A;
    logic [3:0]  B;
    logic        IN_VALID;
    logic [1:0]  MODE;
    logic [3:0]  CLR;
    logic [3:0]  X;
    logic        OUT_VALID;
    logic        ANY;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [3:0]  b;
        logic        v;
        logic [3:0]  x;
    } vec_t;

    vec_t       vecs [11];
    logic [3:0] sbq [$];
    bit         sb_on = 0;

    scs8hd_o4na_sync #(
        .NCH(4),
        .NOR(4),
        .STAGES(2),
        .STRETCH(3)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .A(A),
        .B(B),
        .IN_VALID(IN_VALID),
        .MODE(MODE),
        .CLR(CLR),
        .X(X),
        .OUT_VALID(OUT_VALID),
        .ANY(ANY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [3:0] b);
        IN_VALID = v;
        A        = a;
        B        = b;
    endtask

    // Channel-1 pulse, optional retrigger; X[1] expected high for edges 1..last_high.
    task automatic stretch_run(input int retrig, input int last_high, input int n);
        drive(1'b1, 16'h0010, 4'b0010);
        for (int i = 0; i < n; i++) begin
            cyc();
            if (i == retrig) drive(1'b1, 16'h0010, 4'b0010);
            else             drive(1'b1, 16'h0000, 4'b0000);
            check($sformatf("stretch_x_%0d_%0d", retrig, i), X,
                  (i >= 1 && i <= last_high) ? 32'h2 : 32'h0);
        end
    endtask

    // Scoreboard: every OUT_VALID in pass-mode table section pops one expected X.
    always @(negedge CLK) begin
        if (sb_on && !RESET && OUT_VALID) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: OUT_VALID=1 with X=%0h but no result pending", X);
            end else begin
                logic [3:0] e;
                e = sbq.pop_front();
                check("sb_x", X, e);
                check("sb_any", ANY, |e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{16'h000F, 4'b0000, 1'b1, 4'h0};
        vecs[1]  = '{16'h0000, 4'b0001, 1'b1, 4'h0};
        vecs[2]  = '{16'h0001, 4'b0001, 1'b1, 4'h1};
        vecs[3]  = '{16'h8421, 4'b1111, 1'b1, 4'hF};
        vecs[4]  = '{16'hF0F0, 4'b1111, 1'b1, 4'hA};
        vecs[5]  = '{16'hFFFF, 4'b0101, 1'b1, 4'h5};
        vecs[6]  = '{16'hFFFF, 4'b1111, 1'b0, 4'h0};
        vecs[7]  = '{16'h0100, 4'b0100, 1'b1, 4'h4};
        vecs[8]  = '{16'h1000, 4'b0111, 1'b1, 4'h0};
        vecs[9]  = '{16'hFFFF, 4'b1111, 1'b1, 4'hF};
        vecs[10] = '{16'h0000, 4'b0000, 1'b1, 4'h0};

        RESET = 1'b1;
        MODE  = 2'b00;
        CLR   = 4'b0000;
        drive(1'b0, 16'h0000, 4'b0000);
        cyc();
        cyc();
        check("reset_x", X, 0);
        check("reset_ov", OUT_VALID, 0);
        check("reset_any", ANY, 0);
        RESET = 1'b0;
        cyc();

        // Pass mode, single result, latency 2 and hold afterwards.
        drive(1'b1, 16'h0002, 4'b0001);
        cyc();
        drive(1'b0, 16'h0000, 4'b0000);
        check("lat_ov_early", OUT_VALID, 0);
        check("lat_x_early", X, 0);
        cyc();
        check("lat_ov", OUT_VALID, 1);
        check("lat_x", X, 4'b0001);
        check("lat_any", ANY, 1);
        cyc();
        check("hold_ov", OUT_VALID, 0);
        check("hold_x", X, 4'b0001);

        // Table-driven pass-mode vectors through the scoreboard.
        sb_on = 1;
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].v, vecs[i].a, vecs[i].b);
            if (vecs[i].v) sbq.push_back(vecs[i].x);
            cyc();
        end
        drive(1'b0, 16'h0000, 4'b0000);
        repeat (3) cyc();
        check("sb_drained", sbq.size(), 0);
        sb_on = 0;

        // Sticky mode on channel 2.
        MODE = 2'b01;
        drive(1'b1, 16'h0100, 4'b0100);
        cyc();
        drive(1'b0, 16'h0000, 4'b0000);
        check("sticky_pre", X, 0);
        cyc();
        check("sticky_set", X, 4'b0100);
        cyc();
        check("sticky_hold", X, 4'b0100);
        drive(1'b1, 16'h0100, 4'b0100);
        cyc();
        drive(1'b0, 16'h0000, 4'b0000);
        CLR = 4'b0100;
        cyc();
        check("sticky_set_wins", X, 4'b0100);
        cyc();
        check("sticky_clr", X, 0);
        CLR = 4'b0000;

        // Stretch mode, continuous valid stream of zero results.
        MODE = 2'b10;
        drive(1'b1, 16'h0000, 4'b0000);
        cyc();
        cyc();
        stretch_run(-1, 4, 7);
        stretch_run(1, 6, 9);

        // Switch stretch -> pass while the counter holds 2.
        drive(1'b1, 16'h0010, 4'b0010);
        cyc();
        drive(1'b1, 16'h0000, 4'b0000);
        cyc();
        check("mchg_x1", X, 4'b0010);
        cyc();
        check("mchg_x2", X, 4'b0010);
        MODE = 2'b00;
        cyc();
        check("mchg_x3", X, 4'b0010);
        cyc();
        check("mchg_pass", X, 0);
        check("mchg_any", ANY, 0);

        // Asynchronous reset with two results in flight.
        drive(1'b1, 16'hFFFF, 4'b1111);
        cyc();
        drive(1'b0, 16'h0000, 4'b0000);
        cyc();
        check("pre_rst_x", X, 4'hF);
        drive(1'b1, 16'h0001, 4'b0001);
        cyc();
        drive(1'b1, 16'h1000, 4'b1000);
        #3;
        RESET = 1'b1;
        #1;
        check("arst_x", X, 0);
        check("arst_ov", OUT_VALID, 0);
        check("arst_any", ANY, 0);
        cyc();
        RESET = 1'b0;
        drive(1'b0, 16'h0000, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("post_rst_ov_%0d", i), OUT_VALID, 0);
            check($sformatf("post_rst_x_%0d", i), X, 0);
        end
        drive(1'b1, 16'h0001, 4'b0001);
        cyc();
        drive(1'b0, 16'h0000, 4'b0000);
        check("rlat_ov_early", OUT_VALID, 0);
        cyc();
        check("rlat_ov", OUT_VALID, 1);
        check("rlat_x", X, 4'b0001);
        cyc();
        check("rlat_ov_drop", OUT_VALID, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
